xor4_parity_sequencer: RTL and testbench
========================================

# xor4_parity_sequencer

Sequential controller for the cascaded four-input XOR datapath (partials e = a^b, f = e^c, g = f^d). It time-shares one 2-input XOR stage across three steps, exposes the partials through valid/ready handshakes on both sides, and keeps a saturating count of odd-parity words. It sits between a word producer and any consumer of parity results, replacing three parallel XOR gates with one sequenced stage.

## Interface
- CNT_W, 8, width of odd-parity counter
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, synchronous and active-high
- in_valid  input  1  producer offers a word on a,b,c,d
- in_ready  output  1  block can accept a word this cycle
- a, b, c, d  input  1 each  input word bits, sampled only on accept
- out_valid  output  1  e,f,g hold a completed result
- out_ready  input  1  consumer takes result this cycle
- e  output  1  partial a^b
- f  output  1  partial a^b^c
- g  output  1  full parity a^b^c^d
- busy  output  1  high in every state except IDLE
- odd_count  output  CNT_W  number of delivered results with g=1
- cnt_clr  input  1  synchronous clear of odd_count

## Operation
- States: IDLE, S1, S2, S3, DONE. Encoding free; one XOR operator instance, operands muxed by state.
- IDLE: in_ready=1. On in_valid: latch a,b,c,d into operand registers, go S1. Otherwise stay.
- S1: e_r <= a_r ^ b_r, go S2.
- S2: f_r <= e_r ^ c_r, go S3.
- S3: g_r <= f_r ^ d_r, go DONE.
- DONE: out_valid=1. On out_ready: go IDLE, odd_count increments if g_r=1. Otherwise hold.
- e,f,g drive e_r,f_r,g_r directly and stay stable from DONE entry until the next accepted word reaches S1. e_r, f_r, g_r are all cleared on acceptance (edge into S1).
- in_ready=0 in S1..DONE. in_valid and operand bits are ignored outside IDLE.
- odd_count saturates at 2^CNT_W-1; no wrap.
- cnt_clr: odd_count <= 0 on the edge. If it coincides with an increment, clear wins and the result is 0.
- rst: all state returns to IDLE on the edge. An in-flight word is discarded and not counted.

## Timing
- Reset values: in_ready=1 (IDLE), out_valid=0, busy=0, e=f=g=0, odd_count=0. in_ready is high in the first cycle after reset.
- Accept at edge k (IDLE, in_valid=1):
  - S1 during k..k+1.
  - e valid after edge k+1.
  - f valid after edge k+2.
  - g valid and out_valid=1 after edge k+3.
- Latency: 3 cycles from accept edge to out_valid.
- With out_ready held high:
  - Result is taken at edge k+4 and the block returns to IDLE.
  - The next accept is at edge k+5.
  - Peak throughput is one word per 5 cycles.
- Backpressure: out_valid, e, f and g hold indefinitely while out_ready=0. No result is ever dropped or overwritten.
- out_ready outside DONE has no effect.
- odd_count updates on the DONE handshake edge and is visible the following cycle.

## Test plan
- Reset, then word a,b,c,d=1,0,1,1 with out_ready=1. Required: e=1, f=0, g=1; out_valid exactly 3 cycles after accept; odd_count=1 one cycle after handshake.
- Sweep all 16 words 0000..1111 back to back with in_valid held high. Required:
  - Each g equals the XOR of its bits.
  - Accepts are spaced exactly 5 cycles apart.
  - odd_count=8 at the end.
- Word 1,1,1,0 with out_ready=0 for 10 cycles, then 1. Required:
  - out_valid, e=0, f=1, g=1 are stable throughout the stall.
  - in_ready=0 throughout the stall.
  - Exactly one count increment.
- CNT_W=2, deliver 5 odd words. Required: odd_count sequence 1,2,3,3,3.
- Odd word handshake with cnt_clr=1 on the same edge. Required: odd_count=0.
- Assert rst in S2 of word 1,0,0,0. Required: next cycle IDLE, out_valid=0, e=f=g=0, odd_count unchanged at 0, in_ready=1.

Source files
------------

// File: rtl/xor4_parity_sequencer.sv
// Four-input parity computed over three steps through one shared 2-input XOR,
// with valid/ready handshakes on both sides and a saturating odd-parity count.
module xor4_parity_sequencer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             d,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             e,
    output logic             f,
    output logic             g,
    output logic             busy,
    output logic [CNT_W-1:0] odd_count,
    input  logic             cnt_clr
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        S1   = 3'd1,
        S2   = 3'd2,
        S3   = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t state;
    state_t state_nxt;

    logic a_r, b_r, c_r, d_r;
    logic e_r, f_r, g_r;
    logic x_lhs, x_rhs, x_out;
    logic accept, take;

    // Operands of the single XOR stage are selected by the current step.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        x_lhs     = 1'b0;
        x_rhs     = 1'b0;
        accept    = 1'b0;
        take      = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = S1;
                end
            end
            S1: begin
                x_lhs     = a_r;
                x_rhs     = b_r;
                state_nxt = S2;
            end
            S2: begin
                x_lhs     = e_r;
                x_rhs     = c_r;
                state_nxt = S3;
            end
            S3: begin
                x_lhs     = f_r;
                x_rhs     = d_r;
                state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    take      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign x_out = x_lhs ^ x_rhs;
    assign busy  = (state != IDLE);
    assign e     = e_r;
    assign f     = f_r;
    assign g     = g_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_r   <= 1'b0;
            b_r   <= 1'b0;
            c_r   <= 1'b0;
            d_r   <= 1'b0;
            e_r   <= 1'b0;
            f_r   <= 1'b0;
            g_r   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                a_r <= a;
                b_r <= b;
                c_r <= c;
                d_r <= d;
                e_r <= 1'b0;
                f_r <= 1'b0;
                g_r <= 1'b0;
            end
            if (state == S1) e_r <= x_out;
            if (state == S2) f_r <= x_out;
            if (state == S3) g_r <= x_out;
        end
    end

    // Clear takes priority over a coincident increment.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            odd_count <= '0;
        end else if (take && g_r && (odd_count != CNT_MAX)) begin
            odd_count <= odd_count + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_xor4_parity_sequencer.sv
// Randomized and directed bench for xor4_parity_sequencer; a second instance
// with a 2-bit counter shares the stimulus to exercise saturation.
module tb_xor4_parity_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic       a, b, c, d;
    logic       out_valid;
    logic       out_ready;
    logic       e, f, g;
    logic       busy;
    logic [7:0] odd_count;
    logic       cnt_clr;

    logic       in_ready2, out_valid2, e2, f2, g2, busy2;
    logic [1:0] odd_count2;

    int n_tests = 0;
    int n_fail  = 0;
    int cnt8    = 0;
    int cnt2    = 0;
    int cyc     = 0;
    int acc_q[$];

    always #5 clk = ~clk;

    xor4_parity_sequencer #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c(c), .d(d), .out_valid(out_valid),
        .out_ready(out_ready), .e(e), .f(f), .g(g), .busy(busy),
        .odd_count(odd_count), .cnt_clr(cnt_clr)
    );

    xor4_parity_sequencer #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .a(a), .b(b), .c(c), .d(d), .out_valid(out_valid2),
        .out_ready(out_ready), .e(e2), .f(f2), .g(g2), .busy(busy2),
        .odd_count(odd_count2), .cnt_clr(cnt_clr)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && in_valid && in_ready) acc_q.push_back(cyc);
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic deliver(input logic [3:0] w, input int stall,
                           input bit clr, input bit keep);
        logic       ee, ff, gg;
        logic [3:0] junk;
        ee = w[3] ^ w[2];
        ff = ee ^ w[1];
        gg = ff ^ w[0];
        check("idle_in_ready", in_ready, 1);
        in_valid  = 1'b1;
        {a, b, c, d} = w;
        out_ready = (stall == 0);
        @(negedge clk);
        junk = 4'($urandom);
        {a, b, c, d} = junk;
        check("s1_busy", busy, 1);
        check("s1_in_ready", in_ready, 0);
        check("s1_efg_clr", {e, f, g}, 0);
        check("s1_out_valid", out_valid, 0);
        @(negedge clk);
        check("e", e, ee);
        check("s2_out_valid", out_valid, 0);
        @(negedge clk);
        check("f", f, ff);
        check("s3_out_valid", out_valid, 0);
        @(negedge clk);
        check("out_valid", out_valid, 1);
        check("efg", {e, f, g}, {ee, ff, gg});
        check("dut2_g", g2, gg);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("stall_out_valid", out_valid, 1);
            check("stall_efg", {e, f, g}, {ee, ff, gg});
            check("stall_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        cnt_clr   = clr;
        if (!keep) in_valid = 1'b0;
        @(negedge clk);
        if (clr) begin
            cnt8 = 0;
            cnt2 = 0;
        end else if (gg) begin
            cnt8 = (cnt8 < 255) ? cnt8 + 1 : 255;
            cnt2 = (cnt2 < 3) ? cnt2 + 1 : 3;
        end
        check("odd_count", odd_count, cnt8);
        check("odd_count2", odd_count2, cnt2);
        check("post_out_valid", out_valid, 0);
        check("post_in_ready", in_ready, 1);
        check("post_efg_hold", {e, f, g}, {ee, ff, gg});
        cnt_clr   = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] rw;
        rst = 1'b1;
        in_valid = 1'b0;
        {a, b, c, d} = 4'b0;
        out_ready = 1'b0;
        cnt_clr = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_efg", {e, f, g}, 0);
        check("rst_odd_count", odd_count, 0);
        rst = 1'b0;

        deliver(4'b1011, 0, 1'b0, 1'b0);

        acc_q.delete();
        for (int w = 0; w < 16; w++) deliver(4'(w), 0, 1'b0, w != 15);
        check("sweep_accepts", acc_q.size(), 16);
        for (int i = 1; i < acc_q.size(); i++)
            check("sweep_spacing", acc_q[i] - acc_q[i-1], 5);
        check("sweep_count", odd_count, 9);

        deliver(4'b1110, 10, 1'b0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            rw = 4'($urandom);
            deliver(rw, int'($urandom_range(0, 3)),
                    ($urandom_range(0, 7) == 0), 1'b0);
        end

        deliver(4'b0001, 0, 1'b1, 1'b0);
        check("clr_wins", odd_count, 0);
        for (int i = 0; i < 5; i++) deliver(4'b0111, 0, 1'b0, 1'b0);
        check("sat_final", odd_count2, 3);

        deliver(4'b0000, 0, 1'b1, 1'b0);
        in_valid = 1'b1;
        {a, b, c, d} = 4'b1000;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rr_in_ready", in_ready, 1);
        check("rr_busy", busy, 0);
        check("rr_out_valid", out_valid, 0);
        check("rr_efg", {e, f, g}, 0);
        check("rr_odd_count", odd_count, 0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
